// File: rtl/alu_branch_pkg.sv
// Shared opcode, state and fault definitions for the alu_branch sequencer,
// plus the sign-extension and opcode-legality helpers used by its modules.
package alu_branch_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    function automatic logic [31:0] sext11(input logic [10:0] v);
        return {{21{v[10]}}, v};
    endfunction

    function automatic logic [31:0] sext9(input logic [8:0] v);
        return {{23{v[8]}}, v};
    endfunction

    function automatic logic is_legal_op(input logic [6:0] op);
        logic legal;
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL: legal = 1'b1;
            default:                                          legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_branch_imm.sv
// Branch/jump offset extraction and word-granular PC adders; every result
// wraps modulo 2^PC_W.
module alu_branch_imm
    import alu_branch_pkg::*;
#(
    parameter int PC_W = 9
) (
    input  logic [PC_W-1:0] pc,
    input  logic [31:0]     instr,
    output logic [PC_W-1:0] pc_inc,
    output logic [PC_W-1:0] br_target,
    output logic [PC_W-1:0] jal_target
);

    logic [31:0] br_off_s;
    logic [31:0] jal_off_s;
    logic        unused_bits_s;

    // Offsets are sign-extended then truncated, so the adders wrap naturally.
    always_comb begin
        br_off_s   = sext11({instr[31], instr[7], instr[30:25], instr[11:9]});
        jal_off_s  = sext9(instr[31:23]);
        pc_inc     = pc + PC_W'(1);
        br_target  = pc + br_off_s[PC_W-1:0];
        jal_target = pc + jal_off_s[PC_W-1:0];
    end

    assign unused_bits_s = ^{br_off_s[31:PC_W], jal_off_s[31:PC_W],
                             instr[22:12], instr[8], instr[6:0]};

endmodule

// File: rtl/alu_branch_seq.sv
// Multi-cycle fetch/decode/exec/mem/writeback sequencer for the alu_branch
// datapath, tolerant of variable-latency instruction and data memories.
module alu_branch_seq
    import alu_branch_pkg::*;
#(
    parameter int PC_W    = 9,
    parameter int RET_W   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    input  logic             cmp_true,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             alu_en,
    output logic             rf_we,
    output logic [PC_W-1:0]  pc,
    output logic [RET_W-1:0] retired,
    output logic             busy,
    output logic             halted,
    output logic [1:0]       fault
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [RET_W-1:0]  ret_q, ret_d;
    logic [1:0]        fault_q, fault_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              imem_req_q, imem_req_d;
    logic              dmem_req_q, dmem_req_d;
    logic              dmem_we_q, dmem_we_d;
    logic              alu_en_q, alu_en_d;
    logic              rf_we_q, rf_we_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;

    logic [PC_W-1:0]   pc_inc_s, br_target_s, jal_target_s;
    logic [6:0]        opcode_s;
    logic              retire_s;
    logic              tmo_hit_s;

    assign opcode_s  = instr_q[6:0];
    assign tmo_hit_s = (tmo_q == TMO_W'(TIMEOUT - 1));

    alu_branch_imm #(.PC_W(PC_W)) u_imm (
        .pc         (pc_q),
        .instr      (instr_q),
        .pc_inc     (pc_inc_s),
        .br_target  (br_target_s),
        .jal_target (jal_target_s)
    );

    // Next-state logic; every return to FETCH carries the new PC and clears the wait counter.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        fault_d  = fault_q;
        tmo_d    = tmo_q;
        retire_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pc_d    = {PC_W{1'b0}};
                    tmo_d   = {TMO_W{1'b0}};
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ST_DECODE;
                end else if (tmo_hit_s) begin
                    fault_d = FAULT_TIMEOUT;
                    state_d = ST_HALT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_DECODE: begin
                if (instr_q == 32'h0000_0000) begin
                    state_d = ST_HALT;
                end else if (is_legal_op(opcode_s)) begin
                    state_d = ST_EXEC;
                end else begin
                    fault_d = FAULT_ILLEGAL;
                    state_d = ST_HALT;
                end
            end
            ST_EXEC: begin
                case (opcode_s)
                    OP_BRANCH: begin
                        pc_d     = cmp_true ? br_target_s : pc_inc_s;
                        retire_s = 1'b1;
                        tmo_d    = {TMO_W{1'b0}};
                        state_d  = ST_FETCH;
                    end
                    OP_LOAD, OP_STORE: begin
                        tmo_d   = {TMO_W{1'b0}};
                        state_d = ST_MEM;
                    end
                    OP_R, OP_I, OP_JAL: begin
                        state_d = ST_WB;
                    end
                    default: begin
                        fault_d = FAULT_ILLEGAL;
                        state_d = ST_HALT;
                    end
                endcase
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    if (opcode_s == OP_STORE) begin
                        pc_d     = pc_inc_s;
                        retire_s = 1'b1;
                        tmo_d    = {TMO_W{1'b0}};
                        state_d  = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (tmo_hit_s) begin
                    fault_d = FAULT_TIMEOUT;
                    state_d = ST_HALT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_WB: begin
                pc_d     = (opcode_s == OP_JAL) ? jal_target_s : pc_inc_s;
                retire_s = 1'b1;
                tmo_d    = {TMO_W{1'b0}};
                state_d  = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Retired-instruction counter sticks at all-ones.
    always_comb begin
        if (retire_s && (ret_q != {RET_W{1'b1}})) begin
            ret_d = ret_q + RET_W'(1);
        end else begin
            ret_d = ret_q;
        end
    end

    // Control outputs decoded from the upcoming state so they can be registered.
    always_comb begin
        imem_req_d = (state_d == ST_FETCH);
        dmem_req_d = (state_d == ST_MEM);
        dmem_we_d  = (state_d == ST_MEM) && (instr_d[6:0] == OP_STORE);
        alu_en_d   = (state_d == ST_EXEC);
        rf_we_d    = (state_d == ST_WB);
        busy_d     = (state_d != ST_IDLE) && (state_d != ST_HALT);
        halted_d   = (state_d == ST_HALT);
    end

    // State and output registers; reset clears the requests without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= {PC_W{1'b0}};
            instr_q    <= 32'h0000_0000;
            ret_q      <= {RET_W{1'b0}};
            fault_q    <= FAULT_NONE;
            tmo_q      <= {TMO_W{1'b0}};
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            alu_en_q   <= 1'b0;
            rf_we_q    <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            ret_q      <= ret_d;
            fault_q    <= fault_d;
            tmo_q      <= tmo_d;
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
            dmem_we_q  <= dmem_we_d;
            alu_en_q   <= alu_en_d;
            rf_we_q    <= rf_we_d;
            busy_q     <= busy_d;
            halted_q   <= halted_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign dmem_req  = dmem_req_q;
    assign dmem_we   = dmem_we_q;
    assign alu_en    = alu_en_q;
    assign rf_we     = rf_we_q;
    assign pc        = pc_q;
    assign retired   = ret_q;
    assign busy      = busy_q;
    assign halted    = halted_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_alu_branch_seq.sv
// Directed bench for alu_branch_seq: an instruction-level model expands each
// instruction into a per-cycle script of inputs and expected outputs.
module tb_alu_branch_seq;

    localparam logic [31:0] I_R    = 32'h002081B3;
    localparam logic [31:0] I_I    = 32'h00100093;
    localparam logic [31:0] I_B    = 32'hFE000CE3;  // branch offset -2
    localparam logic [31:0] I_JAL  = 32'hFE80006F;  // jump offset -3
    localparam logic [31:0] I_LD   = 32'h00002003;
    localparam logic [31:0] I_ST   = 32'h00002023;
    localparam logic [31:0] I_HALT = 32'h00000000;
    localparam logic [31:0] I_BAD  = 32'h0000007F;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        cmp_true = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        imem_req, dmem_req, dmem_we, alu_en, rf_we, busy, halted;
    logic [8:0]  imem_addr, pc;
    logic [31:0] instr;
    logic [15:0] retired;
    logic [1:0]  fault;

    alu_branch_seq dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr), .cmp_true(cmp_true),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .alu_en(alu_en), .rf_we(rf_we), .pc(pc), .retired(retired),
        .busy(busy), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start, iack, dack, cmp;
        logic [31:0] rdata;
        logic        ireq, dreq, dwe, alu, rfw, busy, hlt;
        logic [8:0]  addr;
        logic [15:0] ret;
        logic [1:0]  flt;
        logic [31:0] ins;
    } cyc_t;

    cyc_t        q[$];
    int          m_pc, m_ret;
    logic [31:0] m_instr;
    logic [1:0]  m_fault;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic int wrap(input int v);
        return ((v % 512) + 512) % 512;
    endfunction

    function automatic int b_off(input logic [31:0] x);
        int o;
        o = int'({x[31], x[7], x[30:25], x[11:9]});
        if (x[31]) o = o - 2048;
        return o;
    endfunction

    function automatic int j_off(input logic [31:0] x);
        int o;
        o = int'(x[31:23]);
        if (x[31]) o = o - 512;
        return o;
    endfunction

    task automatic retire();
        if (m_ret < 65535) m_ret++;
    endtask

    task automatic push(input string ph, input logic st, input logic ia, input logic da,
                        input logic cm, input logic [31:0] rd, input logic we);
        cyc_t c;
        c.start = st; c.iack = ia; c.dack = da; c.cmp = cm; c.rdata = rd;
        c.ireq  = (ph == "FETCH");
        c.dreq  = (ph == "MEM");
        c.dwe   = (ph == "MEM") && we;
        c.alu   = (ph == "EXEC");
        c.rfw   = (ph == "WB");
        c.busy  = !((ph == "IDLE") || (ph == "HALT"));
        c.hlt   = (ph == "HALT");
        c.addr  = 9'(m_pc);
        c.ret   = 16'(m_ret);
        c.flt   = m_fault;
        c.ins   = m_instr;
        q.push_back(c);
    endtask

    task automatic gen_start();
        push("IDLE", 1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0);
        m_pc = 0;
    endtask

    task automatic gen_halt(input int n);
        for (int i = 0; i < n; i++) push("HALT", 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    endtask

    // Stray acks and cmp_true are driven high wherever they must be ignored.
    task automatic gen_instr(input logic [31:0] ins, input int ilat, input int dlat, input logic cmp);
        logic [6:0] op;
        logic       st;
        op = ins[6:0];
        st = (op == 7'h23);
        for (int k = 0; k <= ilat && k < 15; k++)
            push("FETCH", 1'b0, k == ilat, 1'b1, 1'b1, (k == ilat) ? ins : ~ins, 1'b0);
        if (ilat >= 15) begin
            m_fault = 2'b10;
            return;
        end
        m_instr = ins;
        push("DECODE", 1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0);
        if (ins == 32'h0) return;
        if (!(op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h23 || op == 7'h63 || op == 7'h6F)) begin
            m_fault = 2'b01;
            return;
        end
        push("EXEC", 1'b0, 1'b1, 1'b1, cmp, 32'h0, 1'b0);
        if (op == 7'h63) begin
            m_pc = wrap(m_pc + (cmp ? b_off(ins) : 1));
            retire();
        end else if (op == 7'h6F) begin
            push("WB", 1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0);
            m_pc = wrap(m_pc + j_off(ins));
            retire();
        end else if (op == 7'h03 || op == 7'h23) begin
            for (int k = 0; k <= dlat; k++)
                push("MEM", 1'b0, 1'b1, k == dlat, 1'b1, 32'h0, st);
            if (!st) push("WB", 1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0);
            m_pc = wrap(m_pc + 1);
            retire();
        end else begin
            push("WB", 1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0);
            m_pc = wrap(m_pc + 1);
            retire();
        end
    endtask

    // The single compare point: outputs checked on the falling edge, then that cycle's inputs applied.
    task automatic run_n(input int n);
        cyc_t c;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            c = q.pop_front();
            @(negedge clk);
            cyc++;
            chk("imem_req", imem_req, c.ireq);
            chk("imem_addr", imem_addr, c.addr);
            chk("pc", pc, c.addr);
            chk("dmem_req", dmem_req, c.dreq);
            chk("dmem_we", dmem_we, c.dwe);
            chk("alu_en", alu_en, c.alu);
            chk("rf_we", rf_we, c.rfw);
            chk("busy", busy, c.busy);
            chk("halted", halted, c.hlt);
            chk("retired", retired, c.ret);
            chk("fault", fault, c.flt);
            chk("instr", instr, c.ins);
            start = c.start; imem_ack = c.iack; dmem_ack = c.dack;
            cmp_true = c.cmp; imem_rdata = c.rdata;
        end
        q.delete();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_imem_req"}, imem_req, 32'd0);
        chk({tag, "_dmem_req"}, dmem_req, 32'd0);
        chk({tag, "_dmem_we"}, dmem_we, 32'd0);
        chk({tag, "_alu_en"}, alu_en, 32'd0);
        chk({tag, "_rf_we"}, rf_we, 32'd0);
        chk({tag, "_pc"}, pc, 32'd0);
        chk({tag, "_retired"}, retired, 32'd0);
        chk({tag, "_busy"}, busy, 32'd0);
        chk({tag, "_halted"}, halted, 32'd0);
        chk({tag, "_fault"}, fault, 32'd0);
        chk({tag, "_instr"}, instr, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        cmp_true = 1'b0; imem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk_reset("reset");
        reset = 1'b0;
        m_pc = 0; m_ret = 0; m_instr = 32'h0; m_fault = 2'b00;
        q.delete();
    endtask

    task automatic pin_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Main program: R, branch wrap, R wrap, branch not taken, I, JAL, LOAD, STORE, HALT.
        do_reset();
        gen_start();
        gen_instr(I_R, 0, 0, 1'b0);
        run_n(1000);
        pin_edge();
        chk("r_pc", pc, 32'd1);
        chk("r_retired", retired, 32'd1);

        gen_instr(I_B, 0, 0, 1'b1);
        run_n(1000);
        pin_edge();
        chk("br_taken_addr", imem_addr, 32'd511);
        chk("br_taken_retired", retired, 32'd2);

        gen_instr(I_R, 1, 0, 1'b0);
        gen_instr(I_R, 0, 0, 1'b0);
        gen_instr(I_B, 0, 0, 1'b0);
        run_n(1000);
        pin_edge();
        chk("br_not_taken_addr", imem_addr, 32'd2);
        chk("br_not_taken_retired", retired, 32'd5);

        gen_instr(I_I, 2, 0, 1'b0);
        gen_instr(I_JAL, 0, 0, 1'b0);
        gen_instr(I_LD, 0, 3, 1'b0);
        gen_instr(I_ST, 0, 1, 1'b0);
        run_n(1000);
        pin_edge();
        chk("mem_pc", pc, 32'd2);
        chk("mem_retired", retired, 32'd9);

        gen_instr(I_HALT, 0, 0, 1'b0);
        gen_halt(4);
        run_n(1000);
        pin_edge();
        chk("halt_halted", halted, 32'd1);
        chk("halt_fault", fault, 32'd0);
        chk("halt_busy", busy, 32'd0);

        // Illegal opcode.
        do_reset();
        gen_start();
        gen_instr(I_BAD, 0, 0, 1'b0);
        gen_halt(3);
        run_n(1000);
        pin_edge();
        chk("illegal_fault", fault, 32'd1);
        chk("illegal_halted", halted, 32'd1);

        // Instruction fetch never acknowledged.
        do_reset();
        gen_start();
        gen_instr(I_R, 99, 0, 1'b0);
        gen_halt(4);
        run_n(1000);
        pin_edge();
        chk("timeout_fault", fault, 32'd2);
        chk("timeout_halted", halted, 32'd1);
        chk("timeout_busy", busy, 32'd0);
        chk("timeout_imem_req", imem_req, 32'd0);

        // Reset asserted between clock edges while a load waits in MEM.
        do_reset();
        gen_start();
        gen_instr(I_LD, 0, 5, 1'b0);
        run_n(6);
        #1;
        reset = 1'b1;
        #1;
        chk_reset("async_reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        pin_edge();
        chk("post_reset_busy", busy, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_branch_seq.md
Name: alu_branch_seq

Overview:
Multi-cycle control sequencer for the alu_branch datapath.
- Fetches 32-bit instructions from a 512-word instruction memory and steps each one through decode, execute, optional memory and writeback.
- Drives the datapath enables, owns the 9-bit PC and resolves branches using the ALU compare flag.
- Sits between the instruction/data memories and the ALU/register-file datapath. Replaces free-running per-clock execution so that memories may take variable latency.

Parameters:
PC_W, 9, PC width in words; the PC wraps modulo 2^PC_W.
RET_W, 16, width of the retired-instruction counter; the counter saturates.
TIMEOUT, 15, maximum cycles to wait for imem_ack/dmem_ack before faulting.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; leaves IDLE and begins fetching at PC 0
imem_req  output  1  instruction fetch request, held until ack
imem_addr  output  PC_W  fetch address, equal to pc
imem_ack  input  1  fetch complete; imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction
instr  output  32  latched current instruction, fed to the datapath decode
cmp_true  input  1  ALU branch-condition result, valid in EXEC
dmem_req  output  1  data memory request (loads/stores), held until ack
dmem_we  output  1  1 = store, valid while dmem_req is high
dmem_ack  input  1  data access complete
alu_en  output  1  datapath ALU operand/result latch enable, one cycle in EXEC
rf_we  output  1  register-file write enable, one cycle in WB
pc  output  PC_W  current program counter
retired  output  RET_W  count of completed instructions
busy  output  1  high in every state except IDLE and HALT
halted  output  1  high in HALT
fault  output  2  00 none, 01 illegal opcode, 10 memory timeout

Behaviour:
- Reset (async, any state): state IDLE; pc, retired, instr and fault = 0. All request and enable outputs = 0; busy and halted = 0.
- Opcode is instr[6:0]:
  - R = 0110011
  - I = 0010011
  - LOAD = 0000011
  - STORE = 0100011
  - BRANCH = 1100011
  - JAL = 1101111
  - HALT = instruction 32'h0000_0000
  - anything else is illegal.
- States and transitions:
  - IDLE: wait for start; on start, pc <= 0 and go to FETCH. start is ignored in every other state.
  - FETCH: imem_req = 1. On imem_ack, instr <= imem_rdata and go to DECODE. If ack has not arrived after TIMEOUT waiting cycles, set fault = 10 and go to HALT.
  - DECODE (1 cycle): HALT instruction -> go to HALT, fault stays 00. Illegal opcode -> fault = 01, go to HALT. Otherwise go to EXEC.
  - EXEC (1 cycle): alu_en = 1.
    - BRANCH: if cmp_true, next pc = pc + sext({instr[31],instr[7],instr[30:25],instr[11:9]}) in words, truncated to PC_W; otherwise pc + 1. Then go to FETCH; the branch retires here.
    - JAL: next pc = pc + sext(instr[31:23]); go to WB (link write).
    - LOAD/STORE: go to MEM.
    - R/I: go to WB.
  - MEM: dmem_req = 1, dmem_we = (opcode == STORE). On dmem_ack: STORE goes to FETCH with pc + 1 and retires; LOAD goes to WB. TIMEOUT applies as in FETCH.
  - WB (1 cycle): rf_we = 1. pc <= pc + 1, or the JAL target. Retire, then go to FETCH.
  - HALT: terminal. Only reset leaves it; start is ignored.
- Retire means retired <= retired + 1, saturating at all-ones.
- The PC update takes effect on the transition into FETCH; imem_addr shows the new pc in the first FETCH cycle.
- PC arithmetic wraps: 511 + 1 = 0, and 0 + (−1) = 511.
- Minimum latency:
  - R/I and JAL: 4 cycles (FETCH with same-cycle ack, DECODE, EXEC, WB).
  - BRANCH: 3 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
- A memory ack arriving outside its own request state is ignored.
- The timeout counter clears on every entry to FETCH or MEM.
- Reset asserted mid-request drops imem_req/dmem_req immediately (asynchronously).

Decomposition:
- Shared package alu_branch_pkg holds:
  - opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL)
  - the state encoding (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT)
  - fault codes.
- One natural sub-module, alu_branch_imm: a combinational branch/jump offset extractor and PC adder with wrap.
- The FSM, timeout counter and retire counter stay in the top module.

Test Plan:
- R-type at pc 0, imem_ack the same cycle as req -> alu_en pulses in cycle 3, rf_we in cycle 4, pc = 1, retired = 1.
- BRANCH with offset −2 at pc 1, cmp_true = 1 -> next imem_addr = 511 (wrap), retired increments, no rf_we.
- Same branch with cmp_true = 0 -> imem_addr = 2.
- LOAD with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we = 0, rf_we once, pc + 1. STORE -> dmem_we = 1 and no rf_we.
- imem_ack never asserted -> after 15 wait cycles: halted = 1, fault = 10, busy = 0. A later start pulse is ignored.
- Instruction 32'h0000_0000 -> HALT with fault = 00. Opcode 7'b1111111 -> fault = 01.
- Reset asserted mid-MEM -> all outputs return to reset values without waiting for a clock edge.
